// File: rtl/fpadd_pipe.sv
// fpadd_pipe: 3-stage pipelined floating-point adder/subtractor with a
// valid/ready handshake, subnormal support and exception flags.
//   S1: unpack, apply sub, resolve specials, compare/swap, align the smaller operand
//   S2: significand add or subtract
//   S3: normalise, round, pack into the output register
// Build macro FPADD_RNE_EN: defined  -> round-to-nearest-even, overflow to +/-inf
//                           undefined -> truncate, overflow clamps to +/-max finite
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (a, b, sub)
//   a, b                operands, W = 1+EXP_W+MAN_W bits
//   sub                 1: a - b, 0: a + b
//   out_valid/out_ready result handshake
//   sum                 result
//   flag_ovf/inv/inx    overflow, invalid, inexact
module fpadd_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W+MAN_W:0] sum,
  output logic               flag_ovf,
  output logic               flag_inv,
  output logic               flag_inx
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int N     = MAN_W + 4;   // hidden + fraction + G + R + S
  localparam int SHMAX = MAN_W + 3;
  localparam int XW    = EXP_W + 2;   // room for carry and rounding increment
  localparam logic [EXP_W-1:0] EONES = '1;
  localparam logic [W-1:0]     QNAN  = {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

  // One shared advance enable: the whole pipe moves or the whole pipe holds.
  logic       en;
  logic [2:0] vld_q;
  assign en        = out_ready || !vld_q[2];
  assign in_ready  = en;
  assign out_valid = vld_q[2];

  // ---------------- S1 ----------------
  logic             sa, sb, nan_a, nan_b, inf_a, inf_b;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign sa    = a[W-1];
  assign sb    = b[W-1] ^ sub;
  assign ea    = a[W-2:MAN_W];
  assign eb    = b[W-2:MAN_W];
  assign fa    = a[MAN_W-1:0];
  assign fb    = b[MAN_W-1:0];
  assign nan_a = (ea == EONES) && (fa != '0);
  assign nan_b = (eb == EONES) && (fb != '0);
  assign inf_a = (ea == EONES) && (fa == '0);
  assign inf_b = (eb == EONES) && (fb == '0);

  logic             s1_spec_d, s1_inv_d, s1_sign_d, s1_esub_d;
  logic [W-1:0]     s1_specv_d;
  logic [EXP_W-1:0] s1_exp_d;
  logic [N-1:0]     s1_ml_d, s1_ms_d;
  logic             s1_spec_q, s1_inv_q, s1_sign_q, s1_esub_q;
  logic [W-1:0]     s1_specv_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [N-1:0]     s1_ml_q, s1_ms_q;

  always_comb begin : s1_comb
    logic             swap, lost;
    logic [EXP_W-1:0] el, es, es_eff;
    logic [MAN_W-1:0] fl, fs;
    logic [N-1:0]     xs;
    int               sh;
    s1_spec_d  = 1'b0;
    s1_inv_d   = 1'b0;
    s1_specv_d = '0;
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
      s1_spec_d  = 1'b1;
      s1_inv_d   = 1'b1;
      s1_specv_d = QNAN;
    end else if (inf_a) begin
      s1_spec_d  = 1'b1;
      s1_specv_d = {sa, EONES, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      s1_spec_d  = 1'b1;
      s1_specv_d = {sb, EONES, {MAN_W{1'b0}}};
    end
    // {exp,frac} order equals magnitude order, so one compare picks the larger.
    swap      = {eb, fb} > {ea, fa};
    el        = swap ? eb : ea;
    es        = swap ? ea : eb;
    fl        = swap ? fb : fa;
    fs        = swap ? fa : fb;
    s1_sign_d = swap ? sb : sa;
    s1_esub_d = sa ^ sb;
    s1_ml_d   = {el != '0, fl, 3'b000};
    xs        = {es != '0, fs, 3'b000};
    s1_exp_d  = (el == '0) ? EXP_W'(1) : el;
    es_eff    = (es == '0) ? EXP_W'(1) : es;
    sh        = int'(s1_exp_d - es_eff);
    if (sh > SHMAX) sh = SHMAX;
    lost = 1'b0;
    for (int i = 0; i < N; i++)
      if (i < sh) lost = lost | xs[i];
    xs      = xs >> sh;
    s1_ms_d = {xs[N-1:1], xs[0] | lost};
  end

  // ---------------- S2 ----------------
  // Smaller magnitude is always subtracted from the larger, so no borrow-out.
  logic [N:0]       s2_sum_d, s2_sum_q;
  logic             s2_spec_q, s2_inv_q, s2_sign_q, s2_esub_q;
  logic [W-1:0]     s2_specv_q;
  logic [EXP_W-1:0] s2_exp_q;
  assign s2_sum_d = s1_esub_q ? ({1'b0, s1_ml_q} - {1'b0, s1_ms_q})
                              : ({1'b0, s1_ml_q} + {1'b0, s1_ms_q});

  // ---------------- S3 ----------------
  logic [W-1:0] s3_sum_d;
  logic         s3_ovf_d, s3_inx_d;

  always_comb begin : s3_comb
    logic [XW-1:0]    e3, e_nrm, eo;
    logic [N-1:0]     m3;
    logic [MAN_W:0]   mm;
    logic [MAN_W+1:0] mr;
    logic [MAN_W-1:0] frac;
    logic             sgn;
    int               lz, lim, sh;
    lz = N;
    for (int i = 0; i < N; i++)
      if (s2_sum_q[i]) lz = N - 1 - i;
    // Left shift stops at effective exponent 1: gradual underflow.
    lim = int'(s2_exp_q) - 1;
    sh  = (lz < lim) ? lz : lim;
    if (s2_sum_q[N]) begin
      m3 = {s2_sum_q[N:2], |s2_sum_q[1:0]};
      e3 = XW'(s2_exp_q) + XW'(1);
    end else begin
      m3 = s2_sum_q[N-1:0] << sh;
      e3 = XW'(s2_exp_q) - XW'(sh);
    end
    mm       = m3[N-1:3];
    s3_inx_d = |m3[2:0];
`ifdef FPADD_RNE_EN
    mr = {1'b0, mm} + {{(MAN_W+1){1'b0}}, m3[2] & (m3[1] | m3[0] | mm[0])};
`else
    mr = {1'b0, mm};
`endif
    // No hidden bit means subnormal: packed exponent 0.
    e_nrm = mm[MAN_W] ? e3 : '0;
    if (mr[MAN_W+1]) begin
      eo   = e_nrm + XW'(1);
      frac = mr[MAN_W:1];
    end else begin
      // Subnormal rounding into the hidden bit becomes the smallest normal.
      eo   = ((e_nrm == '0) && mr[MAN_W]) ? XW'(1) : e_nrm;
      frac = mr[MAN_W-1:0];
    end
    sgn      = ((s2_sum_q == '0) && s2_esub_q) ? 1'b0 : s2_sign_q;
    s3_ovf_d = 1'b0;
    s3_sum_d = {sgn, eo[EXP_W-1:0], frac};
    if (eo >= XW'(EONES)) begin
      s3_ovf_d = 1'b1;
`ifdef FPADD_RNE_EN
      s3_sum_d = {sgn, EONES, {MAN_W{1'b0}}};
`else
      s3_sum_d = {sgn, EONES - EXP_W'(1), {MAN_W{1'b1}}};
`endif
    end
    if (s2_spec_q) begin
      s3_sum_d = s2_specv_q;
      s3_ovf_d = 1'b0;
      s3_inx_d = 1'b0;
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      s1_spec_q  <= 1'b0; s1_inv_q <= 1'b0; s1_sign_q <= 1'b0; s1_esub_q <= 1'b0;
      s1_specv_q <= '0;   s1_exp_q <= '0;   s1_ml_q   <= '0;   s1_ms_q   <= '0;
      s2_spec_q  <= 1'b0; s2_inv_q <= 1'b0; s2_sign_q <= 1'b0; s2_esub_q <= 1'b0;
      s2_specv_q <= '0;   s2_exp_q <= '0;   s2_sum_q  <= '0;
      sum        <= '0;
      flag_ovf   <= 1'b0; flag_inv <= 1'b0; flag_inx  <= 1'b0;
    end else if (en) begin
      vld_q      <= {vld_q[1:0], in_valid};
      s1_spec_q  <= s1_spec_d;  s1_inv_q <= s1_inv_d; s1_sign_q <= s1_sign_d;
      s1_esub_q  <= s1_esub_d;  s1_specv_q <= s1_specv_d;
      s1_exp_q   <= s1_exp_d;   s1_ml_q  <= s1_ml_d;  s1_ms_q   <= s1_ms_d;
      s2_spec_q  <= s1_spec_q;  s2_inv_q <= s1_inv_q; s2_sign_q <= s1_sign_q;
      s2_esub_q  <= s1_esub_q;  s2_specv_q <= s1_specv_q;
      s2_exp_q   <= s1_exp_q;   s2_sum_q <= s2_sum_d;
      sum        <= s3_sum_d;
      flag_ovf   <= s3_ovf_d;   flag_inv <= s2_inv_q; flag_inx  <= s3_inx_d;
    end
  end
endmodule

// File: tb/tb_fpadd_pipe.sv
// Bench for fpadd_pipe at default FP16 parameters. Expected results come from
// a directed table and from an exact-integer reference model.
module tb_fpadd_pipe;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, flag_ovf, flag_inv, flag_inx;
  logic [15:0] a = '0, b = '0, sum;
  logic [18:0] got;
  logic [18:0] exp_q[$];
  logic [18:0] pend = '0, held = '0;
  logic        stall_prev = 1'b0;
  int          n_vec = 0, n_err = 0;

  assign got = {sum, flag_ovf, flag_inv, flag_inx};

  fpadd_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .flag_ovf(flag_ovf), .flag_inv(flag_inv), .flag_inx(flag_inx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [18:0] o, input logic [18:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Exact sum in units of the smallest subnormal (2^-24), then rounded to FP16.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s);
    logic   sx, sy, nx, ny, ix, iy, sg;
    longint vx, vy, t, mag, kept, rem, half, enc;
    int     p, sh;
    sx = x[15]; sy = y[15] ^ s;
    nx = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    ny = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    ix = (x[14:10] == 5'h1F) && (x[9:0] == 0);
    iy = (y[14:10] == 5'h1F) && (y[9:0] == 0);
    if (nx || ny || (ix && iy && sx != sy)) return {16'h7E00, 3'b010};
    if (ix) return {sx, 15'h7C00, 3'b000};
    if (iy) return {sy, 15'h7C00, 3'b000};
    vx = longint'({x[14:10] != 0, x[9:0]}) << ((x[14:10] == 0) ? 0 : int'(x[14:10]) - 1);
    vy = longint'({y[14:10] != 0, y[9:0]}) << ((y[14:10] == 0) ? 0 : int'(y[14:10]) - 1);
    t  = (sx ? -vx : vx) + (sy ? -vy : vy);
    if (t == 0) return {sx & sy, 15'h0, 3'b000};
    sg  = (t < 0);
    mag = sg ? -t : t;
    p = 0;
    for (int i = 0; i < 62; i++) if (mag[i]) p = i;
    sh   = (p > 10) ? p - 10 : 0;
    kept = mag >> sh;
    rem  = mag - (kept << sh);
`ifdef FPADD_RNE_EN
    if (sh > 0) begin
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept++;
    end
`else
    half = 0;
`endif
    enc = (longint'(sh) << 10) + kept;
    if (enc >= 64'h7C00) begin
`ifdef FPADD_RNE_EN
      return {sg, 15'h7C00, 2'b10, rem != 0 || half < 0};
`else
      return {sg, 15'h7BFF, 2'b10, rem != 0};
`endif
    end
    return {sg, enc[14:0], 2'b00, rem != 0};
  endfunction

  function automatic logic [15:0] rnd_op(input logic [15:0] r0);
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 9))
      0:       r[14:10] = 5'h1F;
      1:       r[14:10] = 5'h00;
      2, 3, 4: r[14:10] = r0[14:10] + 5'($urandom_range(0, 2)) - 5'd1;
      5:       r = r0 ^ 16'h8000;
      default: ;
    endcase
    return r;
  endfunction

  // One cycle: check what retires at the coming edge, log what is accepted, clock.
  task automatic tick(output bit acc);
    #1;
    if (stall_prev) chk("stall_hold", got, held);
    if (out_valid && out_ready) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_out: observed %h expected none", got);
      end
      if (exp_q.size() != 0) chk("result", got, exp_q.pop_front());
    end
    stall_prev = out_valid && !out_ready;
    held       = got;
    acc        = in_valid && in_ready;
    if (acc) exp_q.push_back(pend);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit acc;
    int k = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 20) begin tick(acc); k++; end
    chk("drain", 19'(exp_q.size()), 19'h0);
  endtask

  logic [15:0] d_a [14] = '{16'h3C00, 16'h3C00, 16'h3C01, 16'h7BFF, 16'h0001, 16'h0400, 16'h7C00,
                           16'h3C00, 16'h8000, 16'h7C00, 16'h7E01, 16'h0000, 16'hFC00, 16'h3C00};
  logic [15:0] d_b [14] = '{16'h4000, 16'h1000, 16'h1000, 16'h7BFF, 16'h0001, 16'h0001, 16'hFC00,
                           16'h3C00, 16'h8000, 16'h3C00, 16'h3C00, 16'h8000, 16'h7C00, 16'h0001};
  logic        d_s [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                           1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef FPADD_RNE_EN
  logic [18:0] d_e [14] = '{{16'h4200, 3'b000}, {16'h3C00, 3'b001}, {16'h3C02, 3'b001},
                            {16'h7C00, 3'b100}, {16'h0002, 3'b000}, {16'h03FF, 3'b000},
                            {16'h7E00, 3'b010}, {16'h0000, 3'b000}, {16'h8000, 3'b000},
                            {16'h7C00, 3'b000}, {16'h7E00, 3'b010}, {16'h0000, 3'b000},
                            {16'hFC00, 3'b000}, {16'h3C00, 3'b001}};
`else
  logic [18:0] d_e [14] = '{{16'h4200, 3'b000}, {16'h3C00, 3'b001}, {16'h3C01, 3'b001},
                            {16'h7BFF, 3'b100}, {16'h0002, 3'b000}, {16'h03FF, 3'b000},
                            {16'h7E00, 3'b010}, {16'h0000, 3'b000}, {16'h8000, 3'b000},
                            {16'h7C00, 3'b000}, {16'h7E00, 3'b010}, {16'h0000, 3'b000},
                            {16'hFC00, 3'b000}, {16'h3BFF, 3'b001}};
`endif

  initial begin
    bit acc;
    int lat, sent, cyc;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", got, 19'h0);
    chk("reset_valid", {17'h0, out_valid, in_ready}, 19'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency from an empty pipe: accept edge counted as the first.
    a = 16'h3C00; b = 16'h4000; sub = 1'b0; pend = {16'h4200, 3'b000};
    in_valid = 1'b1; out_ready = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin tick(acc); lat++; end
    chk("latency", 19'(lat), 19'd3);
    drain();

    // Directed table, back to back
    for (int i = 0; i < 14; i++) begin
      a = d_a[i]; b = d_b[i]; sub = d_s[i]; pend = d_e[i]; in_valid = 1'b1;
      tick(acc);
    end
    drain();

    // Backpressure: 8 sets with out_ready 1,0,0,1,...
    sent = 0; cyc = 0;
    a = rnd_op(16'h3C00); b = rnd_op(a); sub = 1'($urandom); pend = model(a, b, sub);
    while (sent < 8 && cyc < 100) begin
      in_valid  = 1'b1;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      tick(acc);
      cyc++;
      if (acc) begin
        sent++;
        a = rnd_op(a); b = rnd_op(a); sub = 1'($urandom); pend = model(a, b, sub);
      end
    end
    chk("bp_sent", 19'(sent), 19'd8);
    drain();

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      a = rnd_op(16'h4400); b = rnd_op(a); sub = 1'b0; pend = model(a, b, sub);
      in_valid = 1'b1; out_ready = 1'b1;
      tick(acc);
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out", {sum, 2'b00, out_valid}, 19'h0);
    rst_n = 1'b1;
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (6) tick(acc);

    // Randomized traffic with random valid/ready
    for (int i = 0; i < 400; i++) begin
      a = rnd_op(a); b = rnd_op(a); sub = 1'($urandom); pend = model(a, b, sub);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick(acc);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
